// File: rtl/tc_reg_copy_pkg.sv
// Shared types and helpers for the register copy engine.
// Optional feature macro used by the top: TC_REG_COPY_INC_EN.
package tc_reg_copy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CAPTURE = 2'd2,
        SAVE    = 2'd3
    } state_t;

    // Accept-to-done latency and command throughput, in clock cycles.
    localparam int unsigned CMD_LATENCY = 4;

    // Widest one-hot vector the helper can produce; callers truncate to their width.
    localparam int unsigned ONEHOT_MAX_W = 64;

    // One-hot of idx within an n-entry space; all zeros when idx is out of range.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                       input int unsigned n);
        logic [ONEHOT_MAX_W-1:0] r;
        r = (idx < n) ? ({{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << idx) : '0;
        return r;
    endfunction

endpackage

// File: rtl/tc_reg_copy_engine_decode.sv
// Register index decoder: index -> NUM_REGS-bit one-hot plus an in-range flag.
module tc_onehot_decode
    import tc_reg_copy_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                in_range_o
);

    assign onehot_o   = NUM_REGS'(onehot(32'(idx_i), NUM_REGS));
    assign in_range_o = (32'(idx_i) < NUM_REGS);

endmodule

// File: rtl/tc_reg_copy_engine.sv
// Register copy engine: load strobe on the source register, capture the
// shared read bus, save strobe on the destination register.
// Optional feature macro: TC_REG_COPY_INC_EN adds cmd_inc, added to the
// copied value (carry discarded).
module tc_reg_copy_engine
    import tc_reg_copy_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IDX_W-1:0]     cmd_src,
    input  logic [IDX_W-1:0]     cmd_dst,
`ifdef TC_REG_COPY_INC_EN
    input  logic [BIT_WIDTH-1:0] cmd_inc,
`endif
    output logic [NUM_REGS-1:0]  reg_load,
    output logic [NUM_REGS-1:0]  reg_save,
    input  logic [BIT_WIDTH-1:0] rd_data,
    output logic [BIT_WIDTH-1:0] wr_data,
    output logic                 done,
    output logic                 err
);

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   dst_oh_q, dst_oh_d;
    logic [BIT_WIDTH-1:0]  data_q, data_d;
    logic [NUM_REGS-1:0]   load_q, load_d;
    logic [NUM_REGS-1:0]   save_q, save_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [BIT_WIDTH-1:0]  inc_val;

    logic [NUM_REGS-1:0]   src_oh, dst_oh;
    logic                  src_ok, dst_ok;

    tc_onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
        .idx_i      (cmd_src),
        .onehot_o   (src_oh),
        .in_range_o (src_ok)
    );

    tc_onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
        .idx_i      (cmd_dst),
        .onehot_o   (dst_oh),
        .in_range_o (dst_ok)
    );

`ifdef TC_REG_COPY_INC_EN
    logic [BIT_WIDTH-1:0] inc_q, inc_d;
    assign inc_val = inc_q;
`else
    assign inc_val = '0;
`endif

    // Next state, strobes and datapath updates; strobes default to zero every cycle.
    always_comb begin
        state_d  = state_q;
        dst_oh_d = dst_oh_q;
        data_d   = data_q;
        load_d   = '0;
        save_d   = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef TC_REG_COPY_INC_EN
        inc_d    = inc_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
`ifdef TC_REG_COPY_INC_EN
                    inc_d    = cmd_inc;
`endif
                    // Destination is latched already decoded; source is only needed now.
                    dst_oh_d = dst_oh;
                    if (src_ok && dst_ok) begin
                        state_d = LOAD;
                        load_d  = src_oh;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            LOAD:    state_d = CAPTURE;
            CAPTURE: begin
                // data_q holds the final (incremented) value so wr_data is a plain register in SAVE.
                data_d  = rd_data + inc_val;
                save_d  = dst_oh_q;
                state_d = SAVE;
            end
            SAVE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dst_oh_q <= '0;
            data_q   <= '0;
            load_q   <= '0;
            save_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef TC_REG_COPY_INC_EN
            inc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dst_oh_q <= dst_oh_d;
            data_q   <= data_d;
            load_q   <= load_d;
            save_q   <= save_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef TC_REG_COPY_INC_EN
            inc_q    <= inc_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign reg_load  = load_q;
    assign reg_save  = save_q;
    assign wr_data   = data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tc_reg_copy_engine.sv
// Directed bench for tc_reg_copy_engine with four strobe registers on shared buses.
module tb_tc_reg_copy_engine;

    localparam int unsigned NR = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_src;
    logic [IW-1:0] cmd_dst;
    logic [BW-1:0] cmd_inc;
    logic [NR-1:0] reg_load;
    logic [NR-1:0] reg_save;
    logic [BW-1:0] rd_data;
    logic [BW-1:0] wr_data;
    logic          done;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [BW-1:0] bank [NR];
    logic [NR-1:0] oe = '0;

    always #5 clk = ~clk;

    tc_reg_copy_engine #(.NUM_REGS(NR), .BIT_WIDTH(BW), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
`ifdef TC_REG_COPY_INC_EN
        .cmd_inc   (cmd_inc),
`endif
        .reg_load  (reg_load),
        .reg_save  (reg_save),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err)
    );

    // Strobe registers: a load makes the register drive rd_data for the next cycle.
    always @(posedge clk) oe <= reg_load;

    // Save stores wr_data on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++)
            if (reg_save[i]) bank[i] <= wr_data;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NR; i++)
            if (oe[i]) rd_data = rd_data | bank[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [IW-1:0] s, input logic [IW-1:0] d, input logic [BW-1:0] inc);
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_inc   = inc;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_inc = '0;
        for (int i = 0; i < NR; i++) bank[i] = '0;
        tick(); tick();
        chk("rst_load", 32'(reg_load), 32'h0);
        chk("rst_save", 32'(reg_save), 32'h0);
        chk("rst_wr", 32'(wr_data), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'h1);

        // 1. plain copy reg1 -> reg3
        bank[1] = 8'hA5; bank[3] = 8'h00;
        offer(3'd1, 3'd3, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("cp_c1_load", 32'(reg_load), 32'h2);
        chk("cp_c1_save", 32'(reg_save), 32'h0);
        chk("cp_c1_ready", 32'(cmd_ready), 32'h0);
        chk("cp_c1_done", 32'(done), 32'h0);
        tick();
        chk("cp_c2_strobes", 32'({reg_load, reg_save}), 32'h0);
        tick();
        chk("cp_c3_save", 32'(reg_save), 32'h8);
        chk("cp_c3_load", 32'(reg_load), 32'h0);
        chk("cp_c3_wr", 32'(wr_data), 32'hA5);
        tick();
        chk("cp_c4_done", 32'(done), 32'h1);
        chk("cp_c4_err", 32'(err), 32'h0);
        chk("cp_c4_ready", 32'(cmd_ready), 32'h1);
        chk("cp_c4_save", 32'(reg_save), 32'h0);
        chk("cp_reg3", 32'(bank[3]), 32'hA5);
        chk("cp_reg1", 32'(bank[1]), 32'hA5);
        tick();
        chk("cp_done_pulse", 32'(done), 32'h0);
        chk("cp_wr_hold", 32'(wr_data), 32'hA5);

        // 2. self copy reg2 -> reg2 (+1 when incrementing)
        bank[2] = 8'h3C;
        offer(3'd2, 3'd2, 8'h01);
        tick();
        cmd_valid = 1'b0;
        chk("self_load", 32'(reg_load), 32'h4);
        tick(); tick();
        chk("self_save", 32'(reg_save), 32'h4);
        tick();
        chk("self_done", 32'(done), 32'h1);
        chk("self_err", 32'(err), 32'h0);
`ifdef TC_REG_COPY_INC_EN
        chk("self_reg2", 32'(bank[2]), 32'h3D);
`else
        chk("self_reg2", 32'(bank[2]), 32'h3C);
`endif

`ifdef TC_REG_COPY_INC_EN
        // 3. increment wraps: 0xFF + 2 -> 0x01
        bank[0] = 8'hFF;
        offer(3'd0, 3'd1, 8'h02);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("wrap_wr", 32'(wr_data), 32'h01);
        tick();
        chk("wrap_done", 32'(done), 32'h1);
        chk("wrap_err", 32'(err), 32'h0);
        chk("wrap_reg1", 32'(bank[1]), 32'h01);
`endif

        // 4. out-of-range indices
        bank[0] = 8'h5A;
        offer(3'd5, 3'd0, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("bad_src_done", 32'(done), 32'h1);
        chk("bad_src_err", 32'(err), 32'h1);
        chk("bad_src_strobes", 32'({reg_load, reg_save}), 32'h0);
        chk("bad_src_ready", 32'(cmd_ready), 32'h1);
        tick();
        chk("bad_src_after", 32'({done, err, reg_load, reg_save}), 32'h0);
        offer(3'd0, 3'd4, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("bad_dst_flags", 32'({done, err}), 32'h3);
        chk("bad_dst_strobes", 32'({reg_load, reg_save}), 32'h0);
        tick(); tick();
        chk("bad_strobes_later", 32'({reg_load, reg_save}), 32'h0);
        chk("bad_reg0", 32'(bank[0]), 32'h5A);

        // 5. back-to-back: reg3 -> reg0, then reg0 -> reg2
        offer(3'd3, 3'd0, 8'h00);
        tick();
        offer(3'd0, 3'd2, 8'h00);
        chk("b2b_c1_load", 32'(reg_load), 32'h8);
        tick(); tick(); tick();
        chk("b2b_done1", 32'(done), 32'h1);
        chk("b2b_ready1", 32'(cmd_ready), 32'h1);
        chk("b2b_reg0", 32'(bank[0]), 32'hA5);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_c5_load", 32'(reg_load), 32'h1);
        chk("b2b_c5_done", 32'(done), 32'h0);
        tick(); tick();
        chk("b2b_c7_done", 32'(done), 32'h0);
        tick();
        chk("b2b_done2", 32'(done), 32'h1);
        chk("b2b_reg2", 32'(bank[2]), 32'hA5);

        // 6. reset during CAPTURE abandons the copy
        bank[1] = 8'h11;
        offer(3'd0, 3'd1, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(cmd_ready), 32'h1);
        chk("mid_rst_strobes", 32'({reg_load, reg_save}), 32'h0);
        chk("mid_rst_wr", 32'(wr_data), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        tick();
        chk("mid_rst_c2", 32'({done, reg_save}), 32'h0);
        tick();
        chk("mid_rst_c3", 32'({done, reg_save}), 32'h0);
        chk("mid_rst_reg1", 32'(bank[1]), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
